// File: rtl/opl4_pkg.sv
// OPL4 host-side I/O master shared definitions: MSX port map, bank and state encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package opl4_pkg;

    // MSX I/O port map of the OPL4 cartridge
    localparam logic [7:0] PORT_C4 = 8'hC4;   // FM bank1 address / status
    localparam logic [7:0] PORT_C5 = 8'hC5;   // FM data (both banks)
    localparam logic [7:0] PORT_C6 = 8'hC6;   // FM bank2 address
    localparam logic [7:0] PORT_7E = 8'h7E;   // wave address
    localparam logic [7:0] PORT_7F = 8'h7F;   // wave data

    // Status register BUSY flag position
    localparam int BUSY_BIT = 0;

    typedef enum logic [1:0] {
        BANK_FM1     = 2'd0,
        BANK_FM2     = 2'd1,
        BANK_WAVE    = 2'd2,
        BANK_ILLEGAL = 2'd3
    } bank_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_POLL_GAP,
        S_ADDR_CYC,
        S_ADDR_GAP,
        S_DATA_CYC,
        S_DATA_GAP,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_e;

    function automatic logic [7:0] addr_port(input bank_e b);
        case (b)
            BANK_FM2:  return PORT_C6;
            BANK_WAVE: return PORT_7E;
            default:   return PORT_C4;
        endcase
    endfunction

    function automatic logic [7:0] data_port(input bank_e b);
        case (b)
            BANK_WAVE: return PORT_7F;
            default:   return PORT_C5;
        endcase
    endfunction

endpackage

// File: rtl/opl4_bus_cycle.sv
// One MSX I/O bus cycle: SETUP (1 clk), STROBE (STROBE_CYCLES clk), HOLD (1 clk).
// Latency: SETUP begins the clock after i_start; o_done is high during HOLD.
// Backpressure: none; i_start is honoured only while idle or in HOLD (back-to-back cycles).
// Ports: clk/rst; i_start, i_rnw, i_addr, i_wdata request a cycle; o_done, o_rdata report it;
//        o_a, o_dout, o_doe, o_iorq_n, o_rd_n, o_wr_n drive the cartridge bus; i_din is read data.
module opl4_bus_cycle
    import opl4_pkg::*;
#(
    parameter int STROBE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_rnw,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    input  logic [7:0] i_din,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic [7:0] o_a,
    output logic [7:0] o_dout,
    output logic       o_doe,
    output logic       o_iorq_n,
    output logic       o_rd_n,
    output logic       o_wr_n
);

    localparam logic [7:0] STB_LAST = 8'(STROBE_CYCLES - 1);

    phase_e     r_phase;
    logic [7:0] r_cnt;
    logic       r_rnw;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_IDLE;
            r_cnt   <= 8'd0;
            r_rnw   <= 1'b1;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
        end else begin
            case (r_phase)
                PH_IDLE, PH_HOLD: begin
                    if (i_start) begin
                        r_phase <= PH_SETUP;
                        r_rnw   <= i_rnw;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                    end else begin
                        r_phase <= PH_IDLE;
                    end
                end
                PH_SETUP: begin
                    r_phase <= PH_STROBE;
                    r_cnt   <= 8'd0;
                end
                PH_STROBE: begin
                    if (r_cnt == STB_LAST) begin
                        r_phase <= PH_HOLD;
                        // sample on the final strobe clock, while the slave is still driving
                        if (r_rnw) begin
                            r_rdata <= i_din;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

    // address/data stay on the bus after HOLD; only the drive enable and strobes retire
    assign o_done   = (r_phase == PH_HOLD);
    assign o_rdata  = r_rdata;
    assign o_a      = r_addr;
    assign o_dout   = r_wdata;
    assign o_doe    = !r_rnw && (r_phase != PH_IDLE);
    assign o_iorq_n = !(r_phase == PH_STROBE);
    assign o_rd_n   = !((r_phase == PH_STROBE) && r_rnw);
    assign o_wr_n   = !((r_phase == PH_STROBE) && !r_rnw);

endmodule

// File: rtl/opl4_io_master.sv
// OPL4 register access master: one command -> address-port write then data-port read/write.
// Latency: accept at 0, rsp_valid at 5+ADDR_GAP+5+DATA_GAP+1 (23 with defaults), plus polling.
// Backpressure: cmd_ready only in IDLE; one command in flight.
// Ports: clk, rst (sync, active-high); cmd_* request; rsp_* one-cycle completion;
//        bus_* MSX I/O slot signals (bus_d_in from cartridge).
// Build option: define OPL4_BUSY_POLL_EN to poll the status BUSY bit at C4h before each access.
module opl4_io_master
    import opl4_pkg::*;
#(
    parameter int STROBE_CYCLES   = 3,
    parameter int ADDR_GAP_CYCLES = 4,
    parameter int DATA_GAP_CYCLES = 8,
    parameter int POLL_TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_bank,
    input  logic       cmd_rnw,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] bus_a,
    output logic [7:0] bus_d_out,
    output logic       bus_d_oe,
    input  logic [7:0] bus_d_in,
    output logic       bus_iorq_n,
    output logic       bus_rd_n,
    output logic       bus_wr_n
);

    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 256 || POLL_TIMEOUT < 1 || POLL_TIMEOUT > 1023)
    begin : g_bad_param
        $error("opl4_io_master: parameter out of range");
    end

    localparam logic [7:0] ADDR_GAP_LD = (ADDR_GAP_CYCLES > 0) ? 8'(ADDR_GAP_CYCLES - 1) : 8'd0;
    localparam logic [7:0] DATA_GAP_LD = (DATA_GAP_CYCLES > 0) ? 8'(DATA_GAP_CYCLES - 1) : 8'd0;

    state_e     r_state, w_next;
    bank_e      r_bank;
    logic       r_rnw;
    logic [7:0] r_reg, r_data;
    logic [7:0] r_gap_cnt;
    logic [7:0] r_rsp_data;
    logic       r_rsp_err;

    logic       w_accept, w_start, w_cyc_rnw, w_done;
    logic [7:0] w_cyc_addr, w_cyc_wdata, w_rdata;
    bank_e      w_bank;
    logic [7:0] w_reg;

`ifdef OPL4_BUSY_POLL_EN
    localparam logic [9:0] POLL_LAST = 10'(POLL_TIMEOUT - 1);
    logic [9:0] r_poll_cnt;
`endif

    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    // without polling the address cycle launches straight from IDLE, before fields are latched
    assign w_bank = (r_state == S_IDLE) ? bank_e'(cmd_bank) : r_bank;
    assign w_reg  = (r_state == S_IDLE) ? cmd_reg : r_reg;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (bank_e'(cmd_bank) == BANK_ILLEGAL) begin
                        w_next = S_RESP;
                    end else begin
`ifdef OPL4_BUSY_POLL_EN
                        w_next = S_POLL;
`else
                        w_next = S_ADDR_CYC;
`endif
                    end
                end
            end
`ifdef OPL4_BUSY_POLL_EN
            S_POLL:     if (w_done) w_next = S_POLL_GAP;
            S_POLL_GAP: begin
                if (!w_rdata[BUSY_BIT])        w_next = S_ADDR_CYC;
                else if (r_poll_cnt == POLL_LAST) w_next = S_RESP;
                else                           w_next = S_POLL;
            end
`endif
            S_ADDR_CYC: if (w_done) w_next = (ADDR_GAP_CYCLES == 0) ? S_DATA_CYC : S_ADDR_GAP;
            S_ADDR_GAP: if (r_gap_cnt == 8'd0) w_next = S_DATA_CYC;
            S_DATA_CYC: if (w_done) w_next = (DATA_GAP_CYCLES == 0) ? S_RESP : S_DATA_GAP;
            S_DATA_GAP: if (r_gap_cnt == 8'd0) w_next = S_RESP;
            S_RESP:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // a bus cycle is launched one clock ahead so its SETUP coincides with the new state
    always_comb begin
        w_start     = (w_next != r_state) &&
                      (w_next == S_POLL || w_next == S_ADDR_CYC || w_next == S_DATA_CYC);
        w_cyc_rnw   = 1'b1;
        w_cyc_addr  = PORT_C4;
        w_cyc_wdata = 8'h00;
        case (w_next)
            S_ADDR_CYC: begin
                w_cyc_rnw   = 1'b0;
                w_cyc_addr  = addr_port(w_bank);
                w_cyc_wdata = w_reg;
            end
            S_DATA_CYC: begin
                w_cyc_rnw   = r_rnw;
                w_cyc_addr  = data_port(r_bank);
                w_cyc_wdata = r_rnw ? 8'h00 : r_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bank     <= BANK_FM1;
            r_rnw      <= 1'b0;
            r_reg      <= 8'h00;
            r_data     <= 8'h00;
            r_gap_cnt  <= 8'd0;
            r_rsp_data <= 8'h00;
            r_rsp_err  <= 1'b0;
`ifdef OPL4_BUSY_POLL_EN
            r_poll_cnt <= 10'd0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_bank <= bank_e'(cmd_bank);
                r_rnw  <= cmd_rnw;
                r_reg  <= cmd_reg;
                r_data <= cmd_data;
`ifdef OPL4_BUSY_POLL_EN
                r_poll_cnt <= 10'd0;
`endif
            end
            if (w_next == S_ADDR_GAP && r_state != S_ADDR_GAP) begin
                r_gap_cnt <= ADDR_GAP_LD;
            end else if (w_next == S_DATA_GAP && r_state != S_DATA_GAP) begin
                r_gap_cnt <= DATA_GAP_LD;
            end else if (r_state == S_ADDR_GAP || r_state == S_DATA_GAP) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end
            // entering RESP from IDLE means illegal bank; from POLL_GAP means poll timeout
            if (w_next == S_RESP && r_state != S_RESP) begin
                r_rsp_err  <= (r_state == S_IDLE) || (r_state == S_POLL_GAP);
                r_rsp_data <= ((r_state == S_DATA_CYC || r_state == S_DATA_GAP) && r_rnw) ?
                              w_rdata : 8'h00;
            end
`ifdef OPL4_BUSY_POLL_EN
            if (r_state == S_POLL_GAP && w_rdata[BUSY_BIT]) begin
                r_poll_cnt <= r_poll_cnt + 10'd1;
            end
`endif
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    opl4_bus_cycle #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_bus_cycle (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_rnw    (w_cyc_rnw),
        .i_addr   (w_cyc_addr),
        .i_wdata  (w_cyc_wdata),
        .i_din    (bus_d_in),
        .o_done   (w_done),
        .o_rdata  (w_rdata),
        .o_a      (bus_a),
        .o_dout   (bus_d_out),
        .o_doe    (bus_d_oe),
        .o_iorq_n (bus_iorq_n),
        .o_rd_n   (bus_rd_n),
        .o_wr_n   (bus_wr_n)
    );

endmodule

// File: tb/tb_opl4_io_master.sv
module tb_opl4_io_master;
    import opl4_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_bank = 2'd0;
    logic       cmd_rnw = 1'b0;
    logic [7:0] cmd_reg = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] bus_a;
    logic [7:0] bus_d_out;
    logic       bus_d_oe;
    logic [7:0] bus_d_in;
    logic       bus_iorq_n;
    logic       bus_rd_n;
    logic       bus_wr_n;

    always #5 clk = ~clk;

    opl4_io_master #(
        .STROBE_CYCLES(3), .ADDR_GAP_CYCLES(4), .DATA_GAP_CYCLES(8), .POLL_TIMEOUT(1023)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bank(cmd_bank), .cmd_rnw(cmd_rnw),
        .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bus_a(bus_a), .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in),
        .bus_iorq_n(bus_iorq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n)
    );

    typedef struct { logic [7:0] a; logic rd; logic [7:0] wd; } bus_exp_t;
    typedef struct { logic [7:0] data; logic err; int due; } rsp_exp_t;

    bus_exp_t exp_bus[$];
    rsp_exp_t exp_rsp[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int status_reads = 0;
    int busy_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // cartridge model: status busy for the first busy_n reads of a command
    always_comb begin
        bus_d_in = 8'hEE;
        if (bus_a == PORT_C4)      bus_d_in = (status_reads < busy_n) ? 8'h01 : 8'h00;
        else if (bus_a == PORT_7F) bus_d_in = 8'h5A;
        else if (bus_a == PORT_C5) bus_d_in = 8'hA5;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_normal(input int bn);
`ifdef OPL4_BUSY_POLL_EN
        return 23 + 6 * (bn + 1);
`else
        return 23 + 0 * bn;
`endif
    endfunction

    // bus cycle monitor
    logic       in_cyc = 1'b0;
    int         low_cnt = 0;
    logic [7:0] c_a, c_wd;
    logic       c_rd, c_wr, c_oe_any, c_oe_all;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            in_cyc = 1'b0;
        end else if (!bus_iorq_n) begin
            if (!in_cyc) begin
                in_cyc = 1'b1; low_cnt = 0;
                c_a = bus_a; c_wd = bus_d_out; c_rd = !bus_rd_n; c_wr = !bus_wr_n;
                c_oe_any = 1'b0; c_oe_all = 1'b1;
            end
            low_cnt++;
            c_oe_any = c_oe_any | bus_d_oe;
            c_oe_all = c_oe_all & bus_d_oe;
        end else if (in_cyc) begin
            bus_exp_t e;
            in_cyc = 1'b0;
            if (c_a == PORT_C4 && c_rd) status_reads++;
            check("bus_cycle_expected", 32'(exp_bus.size() != 0), 32'd1);
            if (exp_bus.size() != 0) begin
                e = exp_bus.pop_front();
                check("bus_addr", c_a, e.a);
                check("bus_rd_strobe", c_rd, e.rd);
                check("bus_wr_strobe", c_wr, !e.rd);
                check("iorq_low_clocks", low_cnt, 3);
                if (e.rd) check("read_oe_off", c_oe_any, 1'b0);
                else begin
                    check("write_oe_on", c_oe_all, 1'b1);
                    check("bus_wdata", c_wd, e.wd);
                end
            end
        end
    end

    // response monitor
    initial forever begin
        @(negedge clk);
        if (!rst && rsp_valid) begin
            rsp_exp_t r;
            check("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
            check("ready_low_in_resp", cmd_ready, 1'b0);
            if (exp_rsp.size() != 0) begin
                r = exp_rsp.pop_front();
                check("rsp_data", rsp_data, r.data);
                check("rsp_err", rsp_err, r.err);
                check("rsp_latency", cyc, r.due);
            end
        end
    end

    task automatic push_normal(input logic [1:0] bank, input logic rnw,
                               input logic [7:0] rg, input logic [7:0] dt);
`ifdef OPL4_BUSY_POLL_EN
        for (int k = 0; k <= busy_n; k++) exp_bus.push_back('{PORT_C4, 1'b1, 8'h00});
`endif
        exp_bus.push_back('{addr_port(bank_e'(bank)), 1'b0, rg});
        exp_bus.push_back('{data_port(bank_e'(bank)), rnw, dt});
    endtask

    task automatic send(input logic [1:0] bank, input logic rnw, input logic [7:0] rg,
                        input logic [7:0] dt, input int lat, input logic [7:0] xd, input logic xe);
        bit ok;
        status_reads = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_bank = bank; cmd_rnw = rnw; cmd_reg = rg; cmd_data = dt;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        check("cmd_accepted", ok, 1'b1);
        exp_rsp.push_back('{xd, xe, cyc + lat});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("rsp_seen", seen, 1'b1);
        @(negedge clk);
        check("ready_after_rsp", cmd_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_iorq_n", bus_iorq_n, 1'b1);
        check("rst_rd_n", bus_rd_n, 1'b1);
        check("rst_wr_n", bus_wr_n, 1'b1);
        check("rst_bus_a", bus_a, 8'h00);
        check("rst_d_out", bus_d_out, 8'h00);
        check("rst_d_oe", bus_d_oe, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // bank0 write 20h <- 41h
        push_normal(2'd0, 1'b0, 8'h20, 8'h41);
        send(2'd0, 1'b0, 8'h20, 8'h41, lat_normal(0), 8'h00, 1'b0);
        wait_rsp(200);

        // bank2 read 02h, cartridge returns 5Ah
        push_normal(2'd2, 1'b1, 8'h02, 8'h00);
        send(2'd2, 1'b1, 8'h02, 8'h00, lat_normal(0), 8'h5A, 1'b0);
        wait_rsp(200);
        repeat (3) @(negedge clk);
        check("rsp_data_held", rsp_data, 8'h5A);

        // bank1 write 05h <- 77h (C6h/C5h)
        push_normal(2'd1, 1'b0, 8'h05, 8'h77);
        send(2'd1, 1'b0, 8'h05, 8'h77, lat_normal(0), 8'h00, 1'b0);
        wait_rsp(200);

        // illegal bank: immediate error, no bus activity
        send(2'd3, 1'b0, 8'h01, 8'h02, 1, 8'h00, 1'b1);
        wait_rsp(10);

        // bank0 read 08h from C5h
        push_normal(2'd0, 1'b1, 8'h08, 8'h00);
        send(2'd0, 1'b1, 8'h08, 8'h00, lat_normal(0), 8'hA5, 1'b0);
        wait_rsp(200);

        // reset during the data-port write strobe
        push_normal(2'd1, 1'b0, 8'h10, 8'h33);
        send(2'd1, 1'b0, 8'h10, 8'h33, lat_normal(0), 8'h00, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus_a == PORT_C5 && !bus_wr_n) found = 1'b1;
        end
        check("data_strobe_reached", found, 1'b1);
        exp_bus.delete();
        exp_rsp.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_iorq_n", bus_iorq_n, 1'b1);
        check("midrst_wr_n", bus_wr_n, 1'b1);
        check("midrst_rd_n", bus_rd_n, 1'b1);
        check("midrst_d_oe", bus_d_oe, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_cmd_ready", cmd_ready, 1'b1);
        repeat (30) @(negedge clk);

        // new command after reset completes normally
        push_normal(2'd2, 1'b0, 8'h11, 8'h99);
        send(2'd2, 1'b0, 8'h11, 8'h99, lat_normal(0), 8'h00, 1'b0);
        wait_rsp(200);

`ifdef OPL4_BUSY_POLL_EN
        // busy twice, then ready
        busy_n = 2;
        push_normal(2'd0, 1'b0, 8'h20, 8'h41);
        send(2'd0, 1'b0, 8'h20, 8'h41, lat_normal(2), 8'h00, 1'b0);
        wait_rsp(300);
        check("poll_status_reads", status_reads, 3);

        // busy forever: timeout after 1023 reads, no address/data access
        busy_n = 100000;
        for (int k = 0; k < 1023; k++) exp_bus.push_back('{PORT_C4, 1'b1, 8'h00});
        send(2'd1, 1'b0, 8'h22, 8'h44, 1023 * 6 + 1, 8'h00, 1'b1);
        wait_rsp(7000);
        check("timeout_status_reads", status_reads, 1023);
        busy_n = 0;
`endif

        repeat (5) @(negedge clk);
        check("bus_queue_drained", exp_bus.size(), 0);
        check("rsp_queue_drained", exp_rsp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
